// File: rtl/serie_universal_register_if.sv
// Control and data bundle for the universal shift register.
// The master side drives the controls; the slave side (the register) returns contents and frame status.
interface serie_universal_register_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 8
);
    localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

    logic            Ena;
    logic [1:0]      Mode;
    logic            LeRi;
    logic            Data_In;
    logic [WIDTH-1:0] Par_In;
    logic            Data_Out;
    logic [WIDTH-1:0] Par_Out;
    logic [CntW-1:0] Count;
    logic            Done;

    modport master (
        output Ena, Mode, LeRi, Data_In, Par_In,
        input  Data_Out, Par_Out, Count, Done
    );

    modport slave (
        input  Ena, Mode, LeRi, Data_In, Par_In,
        output Data_Out, Par_Out, Count, Done
    );
endinterface

// File: rtl/serie_universal_register.sv
// Universal register: hold, shift, rotate and parallel load, with a frame counter that
// pulses Done for one cycle after every FRAME_LEN-th shift or rotate.
module serie_universal_register #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 8
) (
    input logic                        Clk,
    input logic                        Rst,
    serie_universal_register_if.slave  bus
);
    localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeShift  = 2'b01,
        ModeRotate = 2'b10,
        ModeLoad   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             step;
    logic             fill_bit;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            reg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            reg_q  <= reg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        reg_d    = reg_q;
        step     = 1'b0;
        fill_bit = 1'b0;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (bus.Ena) begin
            unique case (mode_e'(bus.Mode))
                ModeHold: ;
                ModeShift, ModeRotate: begin
                    step = 1'b1;
                    // Shift feeds Data_In; rotate recirculates the bit falling off the other end.
                    if (mode_e'(bus.Mode) == ModeShift) begin
                        fill_bit = bus.Data_In;
                    end else begin
                        fill_bit = bus.LeRi ? reg_q[WIDTH-1] : reg_q[0];
                    end
                    if (bus.LeRi) begin
                        reg_d = {reg_q[WIDTH-2:0], fill_bit};
                    end else begin
                        reg_d = {fill_bit, reg_q[WIDTH-1:1]};
                    end
                end
                ModeLoad: begin
                    reg_d = bus.Par_In;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        if (step) begin
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.Data_Out = bus.LeRi ? reg_q[WIDTH-1] : reg_q[0];
    assign bus.Par_Out  = reg_q;
    assign bus.Count    = cnt_q;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_serie_universal_register.sv
// Scoreboard bench for serie_universal_register at WIDTH=8, FRAME_LEN=8.
module tb_serie_universal_register;
    localparam int unsigned W = 8;
    localparam int unsigned F = 8;

    typedef struct packed {
        logic [7:0] par;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [7:0] m_reg;
    logic [3:0] m_cnt;
    logic       m_done;
    logic       last_dout;
    int         done_seen;

    serie_universal_register_if #(.WIDTH(W), .FRAME_LEN(F)) bus ();

    serie_universal_register #(.WIDTH(W), .FRAME_LEN(F)) dut (
        .Clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict the post-edge state, then compare once the edge has passed.
    task automatic step(input logic rst, input logic ena, input logic [1:0] mode,
                        input logic leri, input logic din, input logic [7:0] par);
        exp_t e;
        @(negedge clk);
        Rst = rst; bus.Ena = ena; bus.Mode = mode; bus.LeRi = leri;
        bus.Data_In = din; bus.Par_In = par;
        #1;
        last_dout = bus.Data_Out;
        check("data_out_pre", {63'd0, bus.Data_Out}, {63'd0, (leri ? m_reg[7] : m_reg[0])});
        m_done = 1'b0;
        if (rst) begin
            m_reg = '0; m_cnt = '0;
        end else if (ena && mode != 2'b00) begin
            if (mode == 2'b11) begin
                m_reg = par; m_cnt = '0;
            end else begin
                if (mode == 2'b01) m_reg = leri ? {m_reg[6:0], din} : {din, m_reg[7:1]};
                else m_reg = leri ? {m_reg[6:0], m_reg[7]} : {m_reg[0], m_reg[7:1]};
                if (m_cnt == 4'(F - 1)) begin
                    m_cnt = '0; m_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end
        sb.push_back('{par: m_reg, cnt: m_cnt, done: m_done});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("par_out", {56'd0, bus.Par_Out}, {56'd0, e.par});
            check("count", {60'd0, bus.Count}, {60'd0, e.cnt});
            check("done", {63'd0, bus.Done}, {63'd0, e.done});
        end
        done_seen += int'(bus.Done);
    endtask

    initial begin
        logic [7:0] seq;
        seq = 8'hA5;
        bus.Ena = 1'b1; bus.Mode = 2'b11; bus.LeRi = 1'b0; bus.Data_In = 1'b1;
        bus.Par_In = 8'hFF;
        m_reg = '0; m_cnt = '0; m_done = 1'b0; done_seen = 0;

        // Reset dominates an enabled parallel load.
        @(posedge clk); #1;
        check("rst_par_out", {56'd0, bus.Par_Out}, 64'h00);
        check("rst_count", {60'd0, bus.Count}, 64'd0);
        check("rst_done", {63'd0, bus.Done}, 64'd0);
        check("rst_data_out", {63'd0, bus.Data_Out}, 64'd0);

        // Load A5, eight left shifts: MSB-first serial stream.
        step(0, 1, 2'b11, 0, 0, 8'hA5);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 1, 0, 8'h00);
            check("a5_serial", {63'd0, last_dout}, {63'd0, seq[7-i]});
            if (i < 7) check("a5_no_early_done", 64'(done_seen), 64'd0);
        end
        check("a5_final", {56'd0, bus.Par_Out}, 64'h00);
        check("a5_done", {63'd0, bus.Done}, 64'd1);
        step(0, 1, 2'b00, 1, 0, 8'h00);
        check("a5_done_one_cycle", {63'd0, bus.Done}, 64'd0);

        // Rotate right 81 -> C0, then back to 81 after eight.
        step(0, 1, 2'b11, 0, 0, 8'h81);
        done_seen = 0;
        step(0, 1, 2'b10, 0, 1, 8'h00);
        check("rot_first", {56'd0, bus.Par_Out}, 64'hC0);
        for (int i = 0; i < 7; i++) step(0, 1, 2'b10, 0, 1, 8'h00);
        check("rot_final", {56'd0, bus.Par_Out}, 64'h81);
        check("rot_count", {60'd0, bus.Count}, 64'd0);
        check("rot_done", {63'd0, bus.Done}, 64'd1);
        step(0, 0, 2'b10, 0, 0, 8'h00);
        check("rot_single_pulse", 64'(done_seen), 64'd1);

        // Reset right after a wrap clears Done at that edge.
        for (int i = 0; i < 8; i++) step(0, 1, 2'b10, 1, 0, 8'h00);
        check("wrap_done", {63'd0, bus.Done}, 64'd1);
        step(1, 1, 2'b01, 1, 0, 8'h00);
        check("rst_after_wrap", {63'd0, bus.Done}, 64'd0);

        // Right shift from zero, then disabled cycles hold everything.
        step(0, 1, 2'b11, 0, 0, 8'h00);
        step(0, 1, 2'b01, 0, 1, 8'h00);
        check("shr_val", {56'd0, bus.Par_Out}, 64'h80);
        check("shr_cnt", {60'd0, bus.Count}, 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 0, 1, 8'h00);
        check("hold_val", {56'd0, bus.Par_Out}, 64'h80);
        check("hold_cnt", {60'd0, bus.Count}, 64'd1);
        check("hold_done", {63'd0, bus.Done}, 64'd0);

        // Reset mid-frame aborts without Done.
        step(0, 1, 2'b11, 0, 0, 8'h3C);
        done_seen = 0;
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 1, 1, 8'h00);
        step(1, 1, 2'b01, 1, 1, 8'h00);
        check("abort_val", {56'd0, bus.Par_Out}, 64'h00);
        check("abort_cnt", {60'd0, bus.Count}, 64'd0);
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Load at Count=7 wins over the wrap; Done comes only after eight more shifts.
        for (int i = 0; i < 7; i++) step(0, 1, 2'b01, 0, 0, 8'h00);
        check("pre_load_cnt", {60'd0, bus.Count}, 64'd7);
        step(0, 1, 2'b11, 0, 0, 8'h5A);
        check("load_cnt", {60'd0, bus.Count}, 64'd0);
        check("load_done", {63'd0, bus.Done}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 7; i++) step(0, 1, 2'b01, 0, 0, 8'h00);
        check("load_no_early_done", 64'(done_seen), 64'd0);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        check("load_late_done", {63'd0, bus.Done}, 64'd1);

        // Data_Out follows LeRi combinationally.
        step(0, 1, 2'b11, 0, 0, 8'h01);
        @(negedge clk);
        bus.Ena = 1'b1; bus.Mode = 2'b00; bus.LeRi = 1'b1;
        #1 check("leri_left", {63'd0, bus.Data_Out}, 64'd0);
        bus.LeRi = 1'b0;
        #1 check("leri_right", {63'd0, bus.Data_Out}, 64'd1);

        // Mixed random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
